// File: rtl/ikaopll_wr_sched.sv
// ikaopll_wr_sched: host-side write scheduler for the IKAOPLL core.
// Buffers (addr, data) write requests in a FIFO and replays each one onto the
// core's CS_n/WR_n/A0/D bus as an address cycle then a data cycle. The YM2413
// wait times are inserted after each strobe, so the host never has to poll.
// All phase timing counts phiM enables (i_phiM_PCEN_n low).
//
// Ports:
//   i_EMUCLK       emulator master clock
//   i_RST          synchronous reset, active-high
//   i_phiM_PCEN_n  phiM enable, active-low
//   i_REQ_VALID    host write request valid
//   o_REQ_READY    FIFO can accept (not full)
//   i_REQ_ADDR     OPLL register address
//   i_REQ_DATA     OPLL register data
//   o_FIFO_LEVEL   entries currently queued
//   o_BUSY         FSM not idle or FIFO non-empty
//   o_CS_n/o_WR_n  to IKAOPLL i_CS_n / i_WR_n
//   o_A0, o_D      to IKAOPLL i_A0 / i_D
//
// Optional build macro: IKAOPLL_WR_SCHED_ADDR_REUSE_EN
//   A write whose address matches the last strobed address skips the address phase.
module ikaopll_wr_sched #(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST,
  input  logic               i_phiM_PCEN_n,
  input  logic               i_REQ_VALID,
  output logic               o_REQ_READY,
  input  logic [7:0]         i_REQ_ADDR,
  input  logic [7:0]         i_REQ_DATA,
  output logic [FIFO_AW:0]   o_FIFO_LEVEL,
  output logic               o_BUSY,
  output logic               o_CS_n,
  output logic               o_WR_n,
  output logic               o_A0,
  output logic [7:0]         o_D
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_A_SETUP = 3'd1;
  localparam logic [2:0] ST_A_STRB  = 3'd2;
  localparam logic [2:0] ST_A_WAIT  = 3'd3;
  localparam logic [2:0] ST_D_SETUP = 3'd4;
  localparam logic [2:0] ST_D_STRB  = 3'd5;
  localparam logic [2:0] ST_D_WAIT  = 3'd6;

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_d;
  logic [7:0]         head_addr, head_data;
  logic [7:0]         addr_q, data_q;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_c, pop_c, empty_c, adv_c, reuse_c;
  logic               cs_c, a0_c, busy_c;
  logic [7:0]         d_c;

  assign empty_c = (o_FIFO_LEVEL == '0);
  assign push_c  = i_REQ_VALID & o_REQ_READY;
  assign adv_c   = (cnt_q == '0) && !i_phiM_PCEN_n;
  assign {head_addr, head_data} = mem[rd_ptr_q];

`ifdef IKAOPLL_WR_SCHED_ADDR_REUSE_EN
  logic       last_valid_q;
  logic [7:0] last_addr_q;

  assign reuse_c = last_valid_q && (head_addr == last_addr_q);

  // Address last presented on the bus, captured when its strobe completes.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      last_valid_q <= 1'b0;
      last_addr_q  <= 8'h00;
    end else if (state_q == ST_A_STRB && adv_c) begin
      last_valid_q <= 1'b1;
      last_addr_q  <= addr_q;
    end
  end
`else
  assign reuse_c = 1'b0;
`endif

  // FIFO storage (no reset needed; validity tracked by level/pointers).
  always_ff @(posedge i_EMUCLK) begin
    if (push_c) mem[wr_ptr_q] <= {i_REQ_ADDR, i_REQ_DATA};
  end

  // Next level; a full FIFO never accepts, even alongside a pop.
  always_comb begin
    level_d = o_FIFO_LEVEL;
    case ({push_c, pop_c})
      2'b10:   level_d = o_FIFO_LEVEL + LVL_W'(1);
      2'b01:   level_d = o_FIFO_LEVEL - LVL_W'(1);
      default: level_d = o_FIFO_LEVEL;
    endcase
  end

  // Next-state and phase counter; counter holds the enables left minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_c   = 1'b0;
    if (!i_phiM_PCEN_n && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = reuse_c ? ST_D_SETUP : ST_A_SETUP;
          cnt_d   = '0;
        end
      end
      ST_A_SETUP: if (adv_c) begin state_d = ST_A_STRB;  cnt_d = CNT_W'(STROBE_LEN - 1); end
      ST_A_STRB:  if (adv_c) begin state_d = ST_A_WAIT;  cnt_d = CNT_W'(ADDR_WAIT - 1);  end
      ST_A_WAIT:  if (adv_c) begin state_d = ST_D_SETUP; cnt_d = '0;                     end
      ST_D_SETUP: if (adv_c) begin state_d = ST_D_STRB;  cnt_d = CNT_W'(STROBE_LEN - 1); end
      ST_D_STRB:  if (adv_c) begin state_d = ST_D_WAIT;  cnt_d = CNT_W'(DATA_WAIT - 1);  end
      ST_D_WAIT: begin
        if (adv_c) begin
          cnt_d = '0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = reuse_c ? ST_D_SETUP : ST_A_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus decode from the current state; A0/D hold outside setup/strobe.
  always_comb begin
    cs_c   = 1'b1;
    a0_c   = o_A0;
    d_c    = o_D;
    busy_c = (state_q != ST_IDLE) || !empty_c;
    case (state_q)
      ST_A_SETUP: begin a0_c = 1'b0; d_c = addr_q; end
      ST_A_STRB:  begin a0_c = 1'b0; d_c = addr_q; cs_c = 1'b0; end
      ST_D_SETUP: begin a0_c = 1'b1; d_c = data_q; end
      ST_D_STRB:  begin a0_c = 1'b1; d_c = data_q; cs_c = 1'b0; end
      default:    ;
    endcase
  end

  // State, FIFO bookkeeping and registered outputs.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      o_FIFO_LEVEL <= '0;
      o_REQ_READY  <= 1'b1;
      o_BUSY       <= 1'b0;
      o_CS_n       <= 1'b1;
      o_WR_n       <= 1'b1;
      o_A0         <= 1'b0;
      o_D          <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_FIFO_LEVEL <= level_d;
      o_REQ_READY  <= (level_d != LVL_W'(DEPTH));
      o_BUSY       <= busy_c;
      o_CS_n       <= cs_c;
      o_WR_n       <= cs_c;
      o_A0         <= a0_c;
      o_D          <= d_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        addr_q   <= head_addr;
        data_q   <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_wr_sched.sv
// tb_ikaopll_wr_sched: directed, self-checking bench for ikaopll_wr_sched.
// Covers reset values, single-write bus timing, FIFO fill/back-pressure with
// back-to-back replay, sparse phiM enable, reset mid-operation and the
// address-reuse build option (IKAOPLL_WR_SCHED_ADDR_REUSE_EN).
module tb_ikaopll_wr_sched;

  logic       clk;
  logic       rst;
  logic       pcen_n;
  logic       vld;
  logic       ready;
  logic [7:0] addr;
  logic [7:0] data;
  logic [4:0] level;
  logic       busy;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sparse   = 1'b0;

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         start;
    int         len;
  } strobe_t;
  strobe_t slog[$];

  // One row: cycles to hold the expectation, enable input, expected bus/busy.
  typedef struct {
    int         len;
    logic       pcen_n;
    logic       cs_n;
    logic       a0;
    logic [7:0] d;
    logic       busy;
  } vec_t;
  vec_t vt[8];

`ifdef IKAOPLL_WR_SCHED_ADDR_REUSE_EN
  localparam int REUSE_GAP = 87;
  localparam int A_STRBS   = 1;
`else
  localparam int REUSE_GAP = 102;
  localparam int A_STRBS   = 2;
`endif

  ikaopll_wr_sched dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phiM_PCEN_n (pcen_n),
    .i_REQ_VALID   (vld),
    .o_REQ_READY   (ready),
    .i_REQ_ADDR    (addr),
    .i_REQ_DATA    (data),
    .o_FIFO_LEVEL  (level),
    .o_BUSY        (busy),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // phiM enable: tied low, or low on every 4th clock in sparse mode.
  initial begin
    int ph;
    ph = 0;
    pcen_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pcen_n = sparse ? (ph != 3) : 1'b0;
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bus monitor: logs each strobe and checks A0/D stay put while CS_n is low.
  initial begin
    logic    prev_cs;
    strobe_t cur;
    prev_cs = 1'b1;
    cur = '{a0: 1'b0, d: 8'h00, start: 0, len: 0};
    forever begin
      @(negedge clk);
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        cur.a0 = a0; cur.d = d; cur.start = cyc;
      end
      if (prev_cs === 1'b0 && cs_n === 1'b0)
        chk("strobe_stable", {23'd0, a0, d}, {23'd0, cur.a0, cur.d});
      if (prev_cs === 1'b0 && cs_n === 1'b1) begin
        cur.len = cyc - cur.start;
        slog.push_back(cur);
      end
      if (cs_n !== wr_n) chk("cs_wr_equal", {31'd0, wr_n}, {31'd0, cs_n});
      prev_cs = cs_n;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request and returns just after the edge that accepts it.
  task automatic push(input logic [7:0] a, input logic [7:0] dv);
    int n;
    vld = 1'b1; addr = a; data = dv;
    n = 0;
    while (!ready && n < 500) begin
      step(1);
      n++;
    end
    chk("push_ready_timeout", {31'd0, ready}, 32'd1);
    step(1);
    vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    step(4);
    n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int na;
    int dstart[2];
    logic [7:0] dval[2];

    vt[0] = '{len: 1,  pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b0, d: 8'h00, busy: 1'b1};
    vt[1] = '{len: 1,  pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b0, d: 8'h10, busy: 1'b1};
    vt[2] = '{len: 2,  pcen_n: 1'b0, cs_n: 1'b0, a0: 1'b0, d: 8'h10, busy: 1'b1};
    vt[3] = '{len: 12, pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b0, d: 8'h10, busy: 1'b1};
    vt[4] = '{len: 1,  pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b1, d: 8'h5A, busy: 1'b1};
    vt[5] = '{len: 2,  pcen_n: 1'b0, cs_n: 1'b0, a0: 1'b1, d: 8'h5A, busy: 1'b1};
    vt[6] = '{len: 84, pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b1, d: 8'h5A, busy: 1'b1};
    vt[7] = '{len: 1,  pcen_n: 1'b0, cs_n: 1'b1, a0: 1'b1, d: 8'h5A, busy: 1'b0};

    rst = 1'b1; vld = 1'b0; addr = 8'h00; data = 8'h00;
    step(3);
    rst = 1'b0;

    // Reset values
    chk("rst_bus",   {21'd0, cs_n, wr_n, a0, d}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h00});
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    // Single write, enable tied low: cycle-by-cycle table after the push edge
    push(8'h10, 8'h5A);
    k = 0;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < vt[r].len; j++) begin
        step(1);
        k++;
        chk($sformatf("single_k%0d", k), {21'd0, pcen_n, cs_n, a0, d, busy},
            {21'd0, vt[r].pcen_n, vt[r].cs_n, vt[r].a0, vt[r].d, vt[r].busy});
      end
    end

    // Burst: 17 accepted (one in flight + 16 queued), 18th held until a pop
    slog.delete();
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i), 8'(i * 7 + 3));
    chk("burst_full_level", {27'd0, level}, 32'd16);
    chk("burst_full_ready", {31'd0, ready}, 32'd0);
    vld = 1'b1; addr = 8'h51; data = 8'(17 * 7 + 3);
    step(1);
    chk("burst_held_ready", {31'd0, ready}, 32'd0);
    chk("burst_held_level", {27'd0, level}, 32'd16);
    k = 0;
    while (!ready && k < 200) begin
      step(1);
      k++;
    end
    chk("burst_pop_ready", {31'd0, ready}, 32'd1);
    chk("burst_pop_level", {27'd0, level}, 32'd15);
    step(1);
    vld = 1'b0;
    chk("burst_retry_level", {27'd0, level}, 32'd16);
    wait_idle(2200);
    chk("burst_strobes", slog.size(), 36);
    if (slog.size() == 36) begin
      for (int i = 0; i < 18; i++) begin
        chk($sformatf("burst_a%0d", i), {23'd0, slog[2*i].a0, slog[2*i].d},
            {23'd0, 1'b0, 8'(8'h40 + i)});
        chk($sformatf("burst_d%0d", i), {23'd0, slog[2*i+1].a0, slog[2*i+1].d},
            {23'd0, 1'b1, 8'(i * 7 + 3)});
        if (i > 0)
          chk($sformatf("burst_gap%0d", i), slog[2*i].start - slog[2*i-2].start, 102);
      end
    end

    // Sparse enable: every 4th clock, two back-to-back writes
    sparse = 1'b1;
    step(4);
    slog.delete();
    push(8'h20, 8'h11);
    push(8'h21, 8'h22);
    wait_idle(1200);
    sparse = 1'b0;
    chk("sparse_strobes", slog.size(), 4);
    if (slog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("sparse_len%0d", i), slog[i].len, 8);
      chk("sparse_write_len", slog[2].start - slog[0].start, 408);
      chk("sparse_order", {slog[0].d, slog[1].d, slog[2].d, slog[3].d}, 32'h20112122);
    end

    // Reset mid-operation with FIFO half full and FSM in the data wait
    step(4);
    for (int i = 0; i < 9; i++) push(8'(8'h50 + i), 8'(i));
    step(30);
    chk("mid_level", {27'd0, level}, 32'd8);
    chk("mid_dwait", {30'd0, cs_n, a0}, {30'd0, 1'b1, 1'b1});
    rst = 1'b1;
    step(1);
    chk("mid_rst_bus",   {21'd0, cs_n, wr_n, a0, d}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h00});
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    slog.delete();
    step(300);
    chk("mid_flushed_strobes", slog.size(), 0);
    chk("mid_flushed_busy", {31'd0, busy}, 32'd0);

    // Same address twice: address phase reuse when the option is built
    do_reset();
    slog.delete();
    push(8'h30, 8'h01);
    push(8'h30, 8'h02);
    wait_idle(400);
    na = 0;
    k = 0;
    dstart[0] = 0; dstart[1] = 0; dval[0] = 8'h00; dval[1] = 8'h00;
    foreach (slog[i]) begin
      if (!slog[i].a0) na++;
      else if (k < 2) begin
        dstart[k] = slog[i].start;
        dval[k] = slog[i].d;
        k++;
      end
    end
    chk("reuse_addr_strobes", na, A_STRBS);
    chk("reuse_data_strobes", k, 2);
    chk("reuse_data_vals", {16'd0, dval[0], dval[1]}, 32'h0102);
    chk("reuse_gap", dstart[1] - dstart[0], REUSE_GAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
